// File: rtl/jk_excite_driver.sv
// jk_excite_driver
// Drives an external W-bit bank of JK flip-flops toward a requested target word.
// A target is taken over a valid/ready handshake, J/K excitation is derived from
// the bank's present Q, held for one cycle, then Q is read back and compared.
// A failed readback re-drives up to MAX_RETRY times before going sticky-error.
//
// Build option: define JK_TOGGLE_FORM_EN to drive every changing bit with the
// toggle excitation (J=K=1) instead of the default set/reset form.
module jk_excite_driver #(
  parameter int W         = 8,
  parameter int MAX_RETRY = 2,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          async_reset_n,
  input  logic          tgt_valid,
  input  logic [W-1:0]  tgt_data,
  output logic          tgt_ready,
  input  logic [W-1:0]  q_in,
  output logic [W-1:0]  j_out,
  output logic [W-1:0]  k_out,
  output logic          done,
  output logic          err,
  input  logic          err_clr,
  output logic [CW-1:0] err_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  logic [1:0]   state;
  logic [3:0]   retry_cnt;
  logic [W-1:0] tgt_r;

  // J term: set/reset form raises J only on 0->1; toggle form on any change.
  function automatic logic [W-1:0] exc_j(input logic [W-1:0] q, input logic [W-1:0] t);
`ifdef JK_TOGGLE_FORM_EN
    return q ^ t;
`else
    return ~q & t;
`endif
  endfunction

  // K term: set/reset form raises K only on 1->0; toggle form on any change.
  function automatic logic [W-1:0] exc_k(input logic [W-1:0] q, input logic [W-1:0] t);
`ifdef JK_TOGGLE_FORM_EN
    return q ^ t;
`else
    return q & ~t;
`endif
  endfunction

  // Saturating increment so a stuck bank cannot wrap the failure counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + CW'(1);
  endfunction

  assign tgt_ready = (state == S_IDLE);

  // Control FSM: handshake, excitation registers, readback verdict and error flag.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state     <= S_IDLE;
      retry_cnt <= '0;
      j_out     <= '0;
      k_out     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      // Excitation is only non-zero for the single cycle spent in DRIVE.
      done  <= 1'b0;
      j_out <= '0;
      k_out <= '0;
      case (state)
        S_IDLE: begin
          if (tgt_valid) begin
            retry_cnt <= '0;
            j_out     <= exc_j(q_in, tgt_data);
            k_out     <= exc_k(q_in, tgt_data);
            state     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (q_in == tgt_r) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            err_count <= sat_inc(err_count);
            if (int'(retry_cnt) < MAX_RETRY) begin
              retry_cnt <= retry_cnt + 4'd1;
              j_out     <= exc_j(q_in, tgt_r);
              k_out     <= exc_k(q_in, tgt_r);
              state     <= S_DRIVE;
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_ERR: begin
          if (err_clr) begin
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Target capture: data-only register, loaded on the accepting handshake.
  always_ff @(posedge clk) begin
    if (tgt_ready && tgt_valid) tgt_r <= tgt_data;
  end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Testbench for jk_excite_driver: behavioural JK bank model, expected-result
// queue filled at each accepted target and drained on done / err rising.
module tb_jk_excite_driver;

  localparam int W  = 8;
  localparam int MR = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          async_reset_n;
  logic          tgt_valid;
  logic [W-1:0]  tgt_data;
  logic          tgt_ready;
  logic [W-1:0]  q_in;
  logic [W-1:0]  j_out, k_out;
  logic          done, err, err_clr;
  logic [CW-1:0] err_count;

  logic [W-1:0]  q_bank = '0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic          stuck = 1'b0;
  int            cyc = 0;
  int            drive_cnt = 0;
  int            n_checks = 0;
  int            n_errors = 0;
  logic          err_q = 1'b0;

  typedef struct {
    logic [W-1:0] tgt;
    int           exp_cyc;
    bit           exp_err;
  } sb_t;
  sb_t sb[$];

  jk_excite_driver #(.W(W), .MAX_RETRY(MR), .CW(CW)) dut (
    .clk(clk), .async_reset_n(async_reset_n),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(tgt_ready),
    .q_in(q_in), .j_out(j_out), .k_out(k_out),
    .done(done), .err(err), .err_clr(err_clr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  assign q_in = stuck ? '0 : q_bank;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] jk_next(input logic [W-1:0] q, input logic [W-1:0] j,
                                           input logic [W-1:0] k);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case ({j[i], k[i]})
        2'b00:   r[i] = q[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  function automatic bit toggle_build();
`ifdef JK_TOGGLE_FORM_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] want_j(input logic [W-1:0] q, input logic [W-1:0] t);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case ({q[i], t[i]})
        2'b01:   r[i] = 1'b1;
        2'b10:   r[i] = toggle_build();
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [W-1:0] want_k(input logic [W-1:0] q, input logic [W-1:0] t);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case ({q[i], t[i]})
        2'b10:   r[i] = 1'b1;
        2'b01:   r[i] = toggle_build();
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Bank model and cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load) q_bank <= load_val;
    else      q_bank <= jk_next(q_bank, j_out, k_out);
  end

  // Output monitor: scoreboard drain, drive-phase counting, exclusivity.
  always @(negedge clk) begin
    sb_t e;
    if (j_out != '0 || k_out != '0) drive_cnt++;
    if (done && err) chk("done_err_excl", 32'(done & err), 0);
    if (done) begin
      chk("sb_nonempty_done", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_kind_done", 32'(e.exp_err), 0);
        chk("sb_q_match", 32'(q_in), 32'(e.tgt));
        chk("sb_latency", 32'(cyc), 32'(e.exp_cyc));
      end
    end
    if (err && !err_q) begin
      chk("sb_nonempty_err", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_kind_err", 32'(e.exp_err), 1);
        chk("sb_err_latency", 32'(cyc), 32'(e.exp_cyc));
      end
    end
    err_q = err;
  end

  task automatic load_bank(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge inside DRIVE.
  task automatic send(input logic [W-1:0] t, input int retries, input bit exp_err,
                      input bit hold_valid);
    int n = 0;
    logic [W-1:0] ej, ek;
    tgt_valid = 1'b1; tgt_data = t;
    while (!tgt_ready && n < 20) begin
      @(negedge clk); n++;
    end
    chk("accept_ready", 32'(tgt_ready), 1);
    ej = want_j(q_in, t);
    ek = want_k(q_in, t);
    sb.push_back('{tgt: t, exp_cyc: cyc + 3 + 2 * retries, exp_err: exp_err});
    @(negedge clk);
    if (!hold_valid) tgt_valid = 1'b0;
    chk("drive_j", 32'(j_out), 32'(ej));
    chk("drive_k", 32'(k_out), 32'(ek));
    chk("drive_not_ready", 32'(tgt_ready), 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk); n++;
    end
    chk("sb_drain", 32'(sb.size()), 0);
  endtask

  initial begin
    int dc0;
    async_reset_n = 1'b0;
    tgt_valid = 1'b0; tgt_data = '0; err_clr = 1'b0;
    #1;
    chk("rst_j", 32'(j_out), 0);
    chk("rst_k", 32'(k_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_cnt", 32'(err_count), 0);
    chk("rst_ready", 32'(tgt_ready), 1);
    repeat (2) @(negedge clk);
    async_reset_n = 1'b1;
    @(negedge clk);

    // Opposite nibbles: every bit changes.
    load_bank(8'h0F);
    send(8'hF0, 0, 1'b0, 1'b0);
    wait_drain();
    chk("bank_f0", 32'(q_in), 32'h F0);

    // Target equal to Q, valid held through CHECK must not be re-accepted.
    load_bank(8'hA5);
    send(8'hA5, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("check_not_ready", 32'(tgt_ready), 0);
    @(negedge clk);
    tgt_valid = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    chk("a5_single_accept", 32'(sb.size()), 0);

    // Bank stuck at zero: retries exhaust into ERR.
    load_bank(8'h00);
    stuck = 1'b1;
    dc0 = drive_cnt;
    send(8'h01, MR, 1'b1, 1'b0);
    wait_drain();
    chk("drive_phases", 32'(drive_cnt - dc0), 32'(MR + 1));
    chk("err_set", 32'(err), 1);
    chk("err_not_ready", 32'(tgt_ready), 0);
    chk("err_count3", 32'(err_count), 3);

    // Clear the error; count persists and the next word completes.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_err", 32'(err), 0);
    chk("clr_ready", 32'(tgt_ready), 1);
    chk("clr_cnt_kept", 32'(err_count), 3);
    load_bank(8'h00);
    stuck = 1'b0;
    send(8'h3C, 0, 1'b0, 1'b0);
    wait_drain();
    chk("post_clr_cnt", 32'(err_count), 3);
    chk("bank_3c", 32'(q_in), 32'h3C);

    // Reset asserted mid-DRIVE aborts the word immediately.
    send(8'hC3, 0, 1'b0, 1'b0);
    #1 async_reset_n = 1'b0;
    #1;
    chk("abort_j", 32'(j_out), 0);
    chk("abort_k", 32'(k_out), 0);
    chk("abort_ready", 32'(tgt_ready), 1);
    chk("abort_cnt", 32'(err_count), 0);
    chk("abort_done", 32'(done), 0);
    sb.delete();
    @(negedge clk);
    async_reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_idle", 32'(tgt_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
